// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the 4-way round-robin output mux/arbiter.
package mux_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching from ptr upward, mod NREQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // SEL_W-bit addition wraps naturally past the last requester.
            w_idx = ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux_arb_rr.sv
// 4:1 round-robin arbitrated mux with one registered output beat and ready/valid handshake.
// Optional burst locking of the previous winner is enabled by defining MUX_ARB_BURST_EN.
module mux_arb_rr
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
`ifdef MUX_ARB_BURST_EN
    input  logic [NREQ-1:0]  lock,
`endif
    input  logic             out_ready,
    output logic [NREQ-1:0]  ack,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_out_sel;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] w_rr_win;
    logic             w_any;
    logic [SEL_W-1:0] w_win;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic             w_capture;
    logic             w_load;
    logic [WIDTH-1:0] w_mux;

    rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_rr_win),
        .any    (w_any)
    );

`ifdef MUX_ARB_BURST_EN
    logic r_prev_vld;
    logic w_lock_hit;

    // Locked previous winner keeps the grant and freezes the pointer.
    assign w_lock_hit = r_prev_vld && lock[r_out_sel] && req[r_out_sel];
    assign w_win      = w_lock_hit ? r_out_sel : w_rr_win;
    assign w_ptr_nxt  = w_lock_hit ? r_ptr : w_rr_win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_vld <= 1'b0;
        end else if (w_load) begin
            r_prev_vld <= 1'b1;
        end
    end
`else
    assign w_win     = w_rr_win;
    assign w_ptr_nxt = w_rr_win + 1'b1;
`endif

    always_comb begin
        case (w_win)
            2'd0:    w_mux = a;
            2'd1:    w_mux = b;
            2'd2:    w_mux = c;
            default: w_mux = d;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        w_load      = 1'b0;
        w_capture   = (r_state == IDLE) || out_ready;
        if (!rst && w_capture) begin
            if (w_any) begin
                w_state_nxt = HOLD;
                ack[w_win]  = 1'b1;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= SEL_W'(RESET_PTR);
            r_out_sel  <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out_data <= w_mux;
                r_out_sel  <= w_win;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameter WIDTH, default 6, data width of each requester and of the output.
REQ-002 Parameter RESET_PTR, default 0, round-robin pointer value after reset (0..3).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req, input, 4, req[i]=1 means requester i presents valid data.
REQ-006 Port a, b, c, d, input, WIDTH each, data of requesters 0, 1, 2, 3.
REQ-007 Port ack, output, 4, one-hot one-cycle pulse: requester's data captured this cycle.
REQ-008 Port out_valid, output, 1, registered output beat valid.
REQ-009 Port out_data, output, WIDTH, registered selected data.
REQ-010 Port out_sel, output, 2, index of requester that sourced out_data.
REQ-011 Port out_ready, input, 1, downstream accepts beat when out_valid and out_ready are both 1.
REQ-012 Port lock, input, 4, present only when MUX_ARB_BURST_EN is defined (see Configuration).

Function
REQ-013 States: IDLE (out_valid=0) and HOLD (out_valid=1, beat pending).
REQ-014 Capture condition: (state==IDLE) or (state==HOLD and out_ready==1).
REQ-015 On capture with any req set, winner = first set req[i] searching ptr, ptr+1, ... mod 4.
REQ-016 On capture with winner w: out_data<=data of w, out_sel<=w, out_valid<=1, ack[w]=1 combinationally that cycle, ptr<=(w+1) mod 4, next state HOLD.
REQ-017 On capture with no req: out_valid<=0, ack=0, ptr unchanged, next state IDLE.
REQ-018 In HOLD with out_ready=0: out_data, out_sel, out_valid, ptr held; ack=0.
REQ-019 Latency: requester data appears on out_data one cycle after its ack pulse.
REQ-020 Back-to-back: HOLD with out_ready=1 and pending req captures next beat same cycle; no bubble.
REQ-021 At most one ack bit set in any cycle; ack never asserted for a requester with req=0.
REQ-022 Pointer wraps 3 -> 0; a continuously requesting set of requesters is served in strict rotation.
REQ-023 req changes during HOLD with out_ready=0 have no effect on outputs.

Reset
REQ-024 On rst=1 at clock edge: state IDLE, out_valid=0, out_data=0, out_sel=0, ptr=RESET_PTR.
REQ-025 ack=0 whenever rst=1, regardless of req.
REQ-026 Reset during HOLD discards the pending beat; no ack or output in the reset cycle.

Configuration
REQ-027 Macro MUX_ARB_BURST_EN defined: lock port exists; on capture, if previous winner p has lock[p]=1 and req[p]=1, winner is p and ptr is not advanced.
REQ-028 MUX_ARB_BURST_EN undefined: lock port absent; arbitration purely round-robin per REQ-015.

Structure
REQ-029 Package mux_arb_pkg holds NREQ=4, SEL_W=2 and the IDLE/HOLD state enum typedef.
REQ-030 Sub-module rr_pick: combinational, inputs req[3:0] and ptr[1:0], outputs winner[1:0] and any.
REQ-031 Data path reuses 4:1 case selection on winner; no additional storage beyond one output register stage.

Verification
REQ-032 Reset with RESET_PTR=0, req=4'b1111, out_ready=1 -> ack sequence 0001,0010,0100,1000,0001; out_sel 0,1,2,3 one cycle later.
REQ-033 req=4'b0100, c=6'h2A, out_ready=0 for 3 cycles -> one ack[2] pulse, out_data=6'h2A, out_valid=1 held 3 cycles, ptr=3.
REQ-034 ptr=3, req=4'b1001 -> winner 3 then 0 (wrap), ptr ends 1.
REQ-035 Assert rst during HOLD with out_valid=1 -> next cycle out_valid=0, out_data=0, ack=0.
REQ-036 MUX_ARB_BURST_EN, lock=4'b0010, req=4'b0011, out_ready=1 -> requester 1 granted every cycle after first grant; drop lock -> requester 0 granted next.
REQ-037 req=0 with out_ready=1 in HOLD -> out_valid falls to 0 next cycle, state IDLE.
